// File: rtl/div_seq_radix2.sv
// div_seq_radix2: iterative restoring divider, signed (DIV) or unsigned (DIVU).
// result = {remainder, quotient}; ready pulses for one cycle when result is valid.
// Optional build macro DIV_RADIX4_EN: retire two quotient bits per cycle
// (two chained restoring stages); results are identical, latency is halved.
//
// Handshake: the requester holds start high until it sees ready=1. Operands are
// sampled only in IDLE. ready is high for exactly the one cycle the FSM spends
// in DONE, and result is valid in that cycle and holds afterwards. annul aborts
// from any state, clears result and suppresses the ready pulse.
module div_seq_radix2 #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     opdata1,
    input  logic [DATA_W-1:0]     opdata2,
    input  logic                  start,
    input  logic                  annul,
    output logic [2*DATA_W-1:0]   result,
    output logic                  ready
);

    localparam int CNT_W = $clog2(DATA_W);
`ifdef DIV_RADIX4_EN
    localparam int ITERS = DATA_W / 2;
`else
    localparam int ITERS = DATA_W;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, DZERO, BUSY, DONE} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   rem;       // partial remainder
    logic [DATA_W-1:0]   dvd;       // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0]   dvs;       // magnitude of divisor
    logic [CNT_W-1:0]    count;
    logic                neg_q, neg_r;

    // One restoring step: returns {next remainder, next dividend/quotient}.
    // The partial remainder stays below the divisor, so after the subtract (or
    // the restore) it always fits back into DATA_W bits.
    function automatic logic [2*DATA_W-1:0] step(input logic [DATA_W-1:0] r,
                                                 input logic [DATA_W-1:0] d,
                                                 input logic [DATA_W-1:0] v);
        logic [DATA_W+1:0] diff;
        diff = {1'b0, r, d[DATA_W-1]} - {2'b00, v};
        if (diff[DATA_W+1])
            step = {r[DATA_W-2:0], d[DATA_W-1], d[DATA_W-2:0], 1'b0};
        else
            step = {diff[DATA_W-1:0], d[DATA_W-2:0], 1'b1};
    endfunction

    logic [DATA_W-1:0] s1_rem, s1_dvd, s_rem, s_dvd;
    logic [DATA_W-1:0] abs1, abs2, q_fix, r_fix;
    logic              sign1, sign2;

    // Iteration datapath, operand magnitudes and final sign correction.
    always_comb begin
        {s1_rem, s1_dvd} = step(rem, dvd, dvs);
`ifdef DIV_RADIX4_EN
        {s_rem, s_dvd} = step(s1_rem, s1_dvd, dvs);
`else
        {s_rem, s_dvd} = {s1_rem, s1_dvd};
`endif
        sign1 = signed_div & opdata1[DATA_W-1];
        sign2 = signed_div & opdata2[DATA_W-1];
        // Negating the most-negative value yields itself, which is the
        // correct unsigned magnitude.
        abs1  = sign1 ? -opdata1 : opdata1;
        abs2  = sign2 ? -opdata2 : opdata2;
        q_fix = neg_q ? -s_dvd : s_dvd;
        r_fix = neg_r ? -s_rem : s_rem;
    end

    // State register: reset, then annul, then normal sequencing.
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else if (annul)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and ready decode.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = (opdata2 == '0) ? DZERO : BUSY;
            DZERO:   state_nxt = DONE;
            BUSY:    if (count == LAST) state_nxt = DONE;
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration registers and result register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rem    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            count  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else if (annul) begin
            count  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    neg_q <= sign1 ^ sign2;
                    neg_r <= sign1;
                    count <= '0;
                    rem   <= '0;
                    dvs   <= abs2;
                    // Divide-by-zero reports the dividend exactly as supplied.
                    dvd   <= (opdata2 == '0) ? opdata1 : abs1;
                end
                DZERO: result <= {dvd, {DATA_W{1'b1}}};
                BUSY: begin
                    rem   <= s_rem;
                    dvd   <= s_dvd;
                    count <= count + 1'b1;
                    if (count == LAST) result <= {r_fix, q_fix};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_radix2.sv
// tb_div_seq_radix2: directed vectors with hand-computed {remainder, quotient};
// drivers push expectations, a negedge monitor pops them on each ready pulse.
module tb_div_seq_radix2;

`ifdef DIV_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif
    localparam int LAT0 = 2;

    logic        clk = 1'b0;
    logic        rst, signed_div, start, annul;
    logic [31:0] opdata1, opdata2;
    logic [63:0] result;
    logic        ready;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        prev_ready = 1'b0;
    logic [63:0] exp_q[$];
    int          exp_cyc_q[$];

    div_seq_radix2 #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .signed_div(signed_div), .opdata1(opdata1),
        .opdata2(opdata2), .start(start), .annul(annul), .result(result),
        .ready(ready)
    );

    // Clock and cycle index.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_step();
        logic [63:0] e;
        int          c;
        if (prev_ready === 1'b1) check64("ready_one_cycle", 64'(ready), 64'd0);
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: ready at cycle %0d with no operation expected", cyc);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check64("result", result, e);
                check64("latency", 64'(cyc), 64'(c));
            end
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        mon_step();
        prev_ready <= ready;
    end

    task automatic wait_ready(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < limit);
        if (ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no ready within %0d cycles", limit);
        end
    endtask

    // Issue one division; scrambles operands during BUSY to show they are
    // ignored, and optionally drops start mid-operation.
    task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input bit drop);
        int n;
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + lat);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                opdata1    = $urandom;
                opdata2    = $urandom_range(1, 1000);
                signed_div = ~sd;
                if (drop) start = 1'b0;
            end
        end while (ready !== 1'b1 && n < lat + 5);
        if (ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: div %h/%h no ready", a, b);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, LAT};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, LAT};
        vecs[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, LAT};
        vecs[3] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, LAT};
        vecs[4] = '{1'b0, 32'h00001234,   32'h00000000,   64'h00001234_FFFFFFFF, LAT0};
        vecs[5] = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, LAT};
        vecs[6] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, LAT};
        vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, LAT};
        vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'h00000010,   64'h0000000F_0FFFFFFF, LAT};
        vecs[9] = '{1'b0, 32'd5,          32'd9,          64'h00000005_00000000, LAT};

        rst = 1'b0; annul = 1'b0; start = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (3) @(negedge clk);
        check64("reset_result", result, 64'd0);
        check64("reset_ready", 64'(ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            do_div(vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, (i == 6));

        // Annul mid-operation: no ready, result cleared; then a fresh op.
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        check64("annul_result", result, 64'd0);
        check64("annul_ready", 64'(ready), 64'd0);
        repeat (LAT + 2) @(negedge clk);
        do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, LAT, 1'b0);

        // Synchronous reset mid-operation.
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check64("midrst_result", result, 64'd0);
        check64("midrst_ready", 64'(ready), 64'd0);
        rst = 1'b1;
        repeat (LAT + 2) @(negedge clk);

        // Back-to-back: start held across DONE, new operands at the DONE cycle.
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        exp_q.push_back(64'h00000002_0000000E);
        exp_cyc_q.push_back(cyc + LAT);
        exp_q.push_back(64'h00000000_00000003);
        exp_cyc_q.push_back(cyc + 2 * LAT + 1);
        wait_ready(LAT + 5);
        opdata1 = 32'd9; opdata2 = 32'd3;
        @(negedge clk);
        wait_ready(LAT + 5);
        start = 1'b0;

        repeat (LAT + 5) @(negedge clk);
        check64("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
